// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM tile sequencer.
//   seq_state_t : sequencer FSM states
//   drain_len() : cycles for the last operand to clear the skewed array
package gemm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // Last beat reaches PE[rows-1][cols-1] after rows-1 + cols-1 extra cycles.
    function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/gemm_skew_line.sv
// Length-N, 1-bit skew line with a tap at every stage.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, clears every stage
//   d_i     : input strobe
//   taps_o  : bit 0 = d_i (no delay), bit i = d_i delayed i cycles
module gemm_skew_line #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         d_i,
    output logic [N-1:0] taps_o
);

    if (N > 1) begin : g_regs
        logic [N-2:0] sr_q;
        logic [N-2:0] sr_d;

        // Shift one stage per cycle; stage 0 captures the live input.
        always_comb begin
            sr_d    = '0;
            sr_d[0] = d_i;
            for (int i = 1; i < int'(N) - 1; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sr_q <= '0;
            end else begin
                sr_q <= sr_d;
            end
        end

        assign taps_o = {sr_q, d_i};
    end else begin : g_wire
        assign taps_o = d_i;
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Sequences one GEMM tile through a C_ROWS x C_COLS systolic array:
// accepts a K-length command, issues K operand beats (stallable by hold),
// emits skewed row/column valids and accumulator clears, waits for the
// array to drain and pulses done.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start_valid/ready     : tile command handshake (ready only in IDLE)
//   k_len                 : beats in the tile, captured on handshake
//   hold                  : operand fetch not ready, suppresses this beat
//   beat_en               : operands presented at the array edge this cycle
//   row_valid/col_valid   : beat_en skewed by row / column index
//   acc_clear             : first-beat strobe skewed by row index
//   busy, done            : tile in flight / one-cycle completion pulse
module gemm_tile_sequencer
    import gemm_pkg::*;
#(
    parameter int unsigned C_ROWS    = 4,
    parameter int unsigned C_COLS    = 4,
    parameter int unsigned C_K_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [C_K_WIDTH-1:0] k_len,
    input  logic                 hold,
    output logic                 beat_en,
    output logic [C_ROWS-1:0]    row_valid,
    output logic [C_COLS-1:0]    col_valid,
    output logic [C_ROWS-1:0]    acc_clear,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned DRAIN_CYC = drain_len(C_ROWS, C_COLS);
    localparam int unsigned DRAIN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    seq_state_t           state_q, state_d;
    logic [C_K_WIDTH-1:0] k_len_q, k_len_d;
    logic [C_K_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 beat_en_c;
    logic                 first_beat_c;

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state, counter updates and beat strobes.
    always_comb begin
        state_d      = state_q;
        k_len_d      = k_len_q;
        beat_cnt_d   = beat_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        beat_en_c    = 1'b0;
        first_beat_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    k_len_d     = k_len;
                    beat_cnt_d  = '0;
                    drain_cnt_d = '0;
                    state_d     = (k_len == '0) ? ST_DONE : ST_FEED;
                end
            end
            ST_FEED: begin
                beat_en_c    = ~hold;
                first_beat_c = ~hold && (beat_cnt_q == '0);
                if (beat_en_c) begin
                    // k_len_q >= 1 here, so k_len_q-1 cannot underflow.
                    if (beat_cnt_q == k_len_q - C_K_WIDTH'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + C_K_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Skew lines keep shifting through DRAIN since beat_en is simply 0 there.
    gemm_skew_line #(.N(C_ROWS)) u_row_skew (
        .clk_i  (clock),
        .rst_i  (reset),
        .d_i    (beat_en_c),
        .taps_o (row_valid)
    );

    gemm_skew_line #(.N(C_COLS)) u_col_skew (
        .clk_i  (clock),
        .rst_i  (reset),
        .d_i    (beat_en_c),
        .taps_o (col_valid)
    );

    gemm_skew_line #(.N(C_ROWS)) u_clr_skew (
        .clk_i  (clock),
        .rst_i  (reset),
        .d_i    (first_beat_c),
        .taps_o (acc_clear)
    );

    assign beat_en     = beat_en_c;
    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
module tb_gemm_tile_sequencer;

    localparam int unsigned R  = 2;
    localparam int unsigned C  = 2;
    localparam int unsigned KW = 4;
    localparam int          D  = R + C - 1;

    typedef struct packed {
        logic         beat;
        logic [R-1:0] row;
        logic [C-1:0] col;
        logic [R-1:0] acc;
        logic         busy;
        logic         done;
        logic         ready;
    } obs_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic [KW-1:0] k_len;
    logic          hold;
    logic          beat_en;
    logic [R-1:0]  row_valid;
    logic [C-1:0]  col_valid;
    logic [R-1:0]  acc_clear;
    logic          busy;
    logic          done;

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_q[$];

    always #5 clock = ~clock;

    gemm_tile_sequencer #(
        .C_ROWS    (R),
        .C_COLS    (C),
        .C_K_WIDTH (KW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .k_len       (k_len),
        .hold        (hold),
        .beat_en     (beat_en),
        .row_valid   (row_valid),
        .col_valid   (col_valid),
        .acc_clear   (acc_clear),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic hold_at(input logic [63:0] sched, input int cyc);
        return (cyc >= 0 && cyc < 64) ? sched[cyc] : 1'b0;
    endfunction

    // Pop the next expected vector and compare against the DUT outputs.
    task automatic check(input string tag, input int cyc);
        obs_t obs;
        obs_t e;
        obs = {beat_en, row_valid, col_valid, acc_clear, busy, done, start_ready};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s cyc=%0d observed=%b expected=<empty scoreboard>", tag, cyc, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_errors++;
                $error("FAIL %s cyc=%0d observed=%b expected=%b (beat,row,col,acc,busy,done,ready)",
                       tag, cyc, obs, e);
            end
        end
    endtask

    // Expected idle vector: everything low except start_ready.
    function automatic obs_t idle_vec();
        obs_t e;
        e       = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // One tile accepted at relative cycle 0. Expected trace is built from the
    // hold schedule alone: beats land on the first k non-held cycles from 1,
    // skews delay by index, done follows the last beat by D+1 cycles.
    task automatic run_tile(input int k, input logic [63:0] hsched,
                            input bit keep_valid, input string tag);
        bit   bt [0:127];
        int   n;
        int   first;
        int   last;
        int   c;
        int   done_c;
        int   ncyc;
        obs_t e;

        for (int i = 0; i < 128; i++) bt[i] = 1'b0;
        n     = 0;
        first = -1;
        last  = 0;
        c     = 1;
        while (n < k && c < 100) begin
            if (!hold_at(hsched, c)) begin
                bt[c] = 1'b1;
                if (first < 0) first = c;
                last = c;
                n++;
            end
            c++;
        end
        done_c = (k == 0) ? 1 : last + D + 1;
        ncyc   = keep_valid ? done_c : done_c + 1;

        for (int cyc = 0; cyc <= ncyc; cyc++) begin
            e      = '0;
            e.beat = bt[cyc];
            for (int i = 0; i < int'(R); i++) begin
                if (cyc - i >= 0) begin
                    e.row[i] = bt[cyc-i];
                    e.acc[i] = (cyc - i == first);
                end
            end
            for (int j = 0; j < int'(C); j++) begin
                if (cyc - j >= 0) e.col[j] = bt[cyc-j];
            end
            e.busy  = (cyc >= 1) && (cyc <= done_c);
            e.done  = (cyc == done_c);
            e.ready = !e.busy;
            exp_q.push_back(e);
        end

        for (int cyc = 0; cyc <= ncyc; cyc++) begin
            start_valid = keep_valid || (cyc == 0);
            // A different length while busy must never be captured.
            k_len       = (cyc == 0) ? KW'(k) : KW'(k + 5);
            hold        = hold_at(hsched, cyc);
            @(negedge clock);
            check(tag, cyc);
            @(posedge clock);
            #1;
        end
        start_valid = 1'b0;
        hold        = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = 1'b0;
        k_len       = '0;
        hold        = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state.
        exp_q.push_back(idle_vec());
        @(negedge clock);
        check("reset_state", 0);
        @(posedge clock);
        #1;

        // Basic tile, no stalls.
        run_tile(4, 64'h0, 1'b0, "k4_nohold");

        // Stalls in cycles 2-3 insert bubbles only.
        run_tile(3, 64'b1100, 1'b0, "k3_hold23");

        // First beat delayed by a stall: acc_clear follows the real first beat.
        run_tile(2, 64'b0110, 1'b0, "k2_hold12");

        // Zero-length tile.
        run_tile(0, 64'h0, 1'b0, "k0");

        // Single-beat tile.
        run_tile(1, 64'h0, 1'b0, "k1");

        // Back-to-back tiles with start_valid held high.
        run_tile(2, 64'h0, 1'b1, "b2b_a");
        run_tile(2, 64'h0, 1'b1, "b2b_b");
        run_tile(2, 64'h0, 1'b0, "b2b_c");

        // Reset on the second FEED beat aborts the tile without done.
        start_valid = 1'b1;
        k_len       = KW'(4);
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            exp_q.push_back(idle_vec());
            @(negedge clock);
            check("abort_idle", cyc);
            @(posedge clock);
            #1;
        end
        run_tile(3, 64'h0, 1'b0, "after_abort");

        // Maximum length, counter must not wrap.
        run_tile(15, 64'h0, 1'b0, "k15_max");

        // Maximum length with scattered stalls.
        run_tile(15, 64'h0000_0000_0002_4A10, 1'b0, "k15_hold");

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
